// File: rtl/adc_capture.sv
// Dual-channel ADC capture: sample-clock divider, offset-binary to two's complement
// conversion, power-of-two boxcar decimation and a small first-word-fall-through FIFO.
module adc_capture #(
    parameter int DW         = 12,
    parameter int CLK_DIV    = 4,
    parameter int CAP_PHASE  = 3,
    parameter int MAX_LOG2   = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [2:0]           decim_log2,
    input  logic                 ovf_clr,
    input  logic [DW-1:0]        ad1_data,
    input  logic [DW-1:0]        ad2_data,
    output logic                 ad1_clk,
    output logic                 ad2_clk,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_ch1,
    output logic signed [DW-1:0] m_ch2,
    output logic                 overflow
);

    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW  = DW + MAX_LOG2;
    localparam int CW  = MAX_LOG2 + 1;
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW  = FAW + 1;

    function automatic logic signed [DW-1:0] to_signed(input logic [DW-1:0] raw);
        to_signed = {~raw[DW-1], raw[DW-2:0]};
    endfunction

    logic [DW-1:0]          r_ad1, r_ad2;
    logic [DCW-1:0]         r_div_cnt, w_div_nxt;
    logic                   r_ad_clk;
    logic                   w_strobe;
    logic [2:0]             r_k, w_k;
    logic [3:0]             w_dec_ext;
    logic [CW-1:0]          r_cnt, w_cnt_last;
    logic                   w_last;
    logic signed [DW-1:0]   w_smp1, w_smp2;
    logic signed [AW-1:0]   r_acc1, r_acc2, w_sum1, w_sum2;
    logic [DW-1:0]          w_res1, w_res2;
    logic                   r_res_vld;
    logic [2*DW-1:0]        r_res;
    logic [2*DW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr, w_count;
    logic                   w_full, w_empty, w_pop, w_push, w_drop;
    logic                   r_ovf;

    // Pin registers, sampled every cycle regardless of enable.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ad1 <= {DW{1'b0}};
            r_ad2 <= {DW{1'b0}};
        end else begin
            r_ad1 <= ad1_data;
            r_ad2 <= ad2_data;
        end
    end

    // Divider next state and capture strobe.
    always_comb begin
        w_div_nxt = {DCW{1'b0}};
        if (!enable) begin
            w_div_nxt = {DCW{1'b0}};
        end else if (r_div_cnt == DCW'(CLK_DIV - 1)) begin
            w_div_nxt = {DCW{1'b0}};
        end else begin
            w_div_nxt = r_div_cnt + DCW'(1);
        end
        w_strobe = enable && (r_div_cnt == DCW'(CAP_PHASE));
    end

    // ADC clock is registered from the next divider count so it lines up with div_cnt.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= {DCW{1'b0}};
            r_ad_clk  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_ad_clk  <= enable && (w_div_nxt < DCW'(CLK_DIV / 2));
        end
    end

    // Block exponent is taken from the input only at the first strobe of a block.
    always_comb begin
        w_dec_ext = {1'b0, decim_log2};
        w_k       = r_k;
        if (r_cnt == {CW{1'b0}}) begin
            if (w_dec_ext > 4'(MAX_LOG2)) begin
                w_k = 3'(MAX_LOG2);
            end else begin
                w_k = decim_log2;
            end
        end else begin
            w_k = r_k;
        end
        w_cnt_last = (CW'(1) << w_k) - CW'(1);
        w_last     = (r_cnt == w_cnt_last);
        w_smp1     = to_signed(r_ad1);
        w_smp2     = to_signed(r_ad2);
        w_sum1     = r_acc1 + AW'(w_smp1);
        w_sum2     = r_acc2 + AW'(w_smp2);
        w_res1     = DW'(w_sum1 >>> w_k);
        w_res2     = DW'(w_sum2 >>> w_k);
    end

    // Accumulate; on the final strobe the accumulator restarts from zero.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc1    <= {AW{1'b0}};
            r_acc2    <= {AW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_k       <= 3'd0;
            r_res_vld <= 1'b0;
            r_res     <= {(2*DW){1'b0}};
        end else begin
            r_res_vld <= w_strobe && w_last;
            if (w_strobe && w_last) begin
                r_res <= {w_res1, w_res2};
            end
            if (!enable) begin
                r_acc1 <= {AW{1'b0}};
                r_acc2 <= {AW{1'b0}};
                r_cnt  <= {CW{1'b0}};
            end else if (w_strobe) begin
                r_k <= w_k;
                if (w_last) begin
                    r_acc1 <= {AW{1'b0}};
                    r_acc2 <= {AW{1'b0}};
                    r_cnt  <= {CW{1'b0}};
                end else begin
                    r_acc1 <= w_sum1;
                    r_acc2 <= w_sum2;
                    r_cnt  <= r_cnt + CW'(1);
                end
            end
        end
    end

    // FIFO status; a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        w_count = r_wr_ptr - r_rd_ptr;
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (w_count == PW'(FIFO_DEPTH));
        w_pop   = !w_empty && m_ready;
        w_push  = r_res_vld && (!w_full || w_pop);
        w_drop  = r_res_vld && w_full && !w_pop;
    end

    // FIFO storage and pointers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {(2*DW){1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[FAW-1:0]] <= r_res;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle wins over the clear.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ad1_clk        = r_ad_clk;
    assign ad2_clk        = r_ad_clk;
    assign m_valid        = !w_empty;
    assign {m_ch1, m_ch2} = r_mem[r_rd_ptr[FAW-1:0]];
    assign overflow       = r_ovf;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: a sample-stream reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_adc_capture;

    localparam int DW        = 12;
    localparam int CLK_DIV   = 4;
    localparam int CAP_PHASE = 3;
    localparam int MAX_LOG2  = 7;
    localparam int DEPTH     = 4;

    logic                 sys_clk, rst_n, enable, ovf_clr, m_ready;
    logic [2:0]           decim_log2;
    logic [DW-1:0]        ad1_data, ad2_data;
    logic                 ad1_clk, ad2_clk, m_valid, overflow;
    logic signed [DW-1:0] m_ch1, m_ch2;

    adc_capture #(.DW(DW), .CLK_DIV(CLK_DIV), .CAP_PHASE(CAP_PHASE),
                  .MAX_LOG2(MAX_LOG2), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .decim_log2(decim_log2),
        .ovf_clr(ovf_clr), .ad1_data(ad1_data), .ad2_data(ad2_data),
        .ad1_clk(ad1_clk), .ad2_clk(ad2_clk), .m_valid(m_valid), .m_ready(m_ready),
        .m_ch1(m_ch1), .m_ch2(m_ch2), .overflow(overflow)
    );

    typedef struct { int c1; int c2; } pair_t;

    int n_total = 0;
    int n_pass  = 0;
    pair_t dut_log[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Reference model: samples are raw-2048, blocks of 2^k strobes averaged with floor.
    pair_t m_q[$];
    pair_t pend;
    int    m_div, m_prev_en, m_ovf, m_prev_a1, m_prev_a2;
    int    blk_n, blk_k, blk_s1, blk_s2, pend_v, pend_due, cyc;
    int    do_pop, do_set;

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_div = 0; m_prev_en = 0; m_ovf = 0; pend_v = 0;
            blk_n = 0; blk_k = 0; blk_s1 = 0; blk_s2 = 0;
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_ad_clk", int'(ad1_clk) + int'(ad2_clk), 0);
        end else begin
            chk("ad1_clk", int'(ad1_clk), (m_prev_en != 0 && m_div < CLK_DIV / 2) ? 1 : 0);
            chk("ad2_clk", int'(ad2_clk), (m_prev_en != 0 && m_div < CLK_DIV / 2) ? 1 : 0);
            chk("m_valid", int'(m_valid), (m_q.size() > 0) ? 1 : 0);
            chk("overflow", int'(overflow), m_ovf);
            if (m_q.size() > 0) begin
                chk("m_ch1", int'(m_ch1), m_q[0].c1);
                chk("m_ch2", int'(m_ch2), m_q[0].c2);
            end
            if (m_valid && m_ready) dut_log.push_back('{int'(m_ch1), int'(m_ch2)});
            do_pop = (m_q.size() > 0 && m_ready) ? 1 : 0;
            do_set = 0;
            if (do_pop != 0) void'(m_q.pop_front());
            if (pend_v != 0 && pend_due == cyc) begin
                if (m_q.size() < DEPTH) m_q.push_back(pend);
                else do_set = 1;
                pend_v = 0;
            end
            if (do_set != 0) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (enable && m_div == CAP_PHASE) begin
                if (blk_n == 0) blk_k = (int'(decim_log2) > MAX_LOG2) ? MAX_LOG2 : int'(decim_log2);
                blk_s1 += m_prev_a1 - 2048;
                blk_s2 += m_prev_a2 - 2048;
                blk_n++;
                if (blk_n == (1 << blk_k)) begin
                    pend = '{blk_s1 >>> blk_k, blk_s2 >>> blk_k};
                    pend_v = 1; pend_due = cyc + 1;
                    blk_n = 0; blk_s1 = 0; blk_s2 = 0;
                end
            end
            if (!enable) begin
                blk_n = 0; blk_s1 = 0; blk_s2 = 0;
            end
            m_div = enable ? (m_div + 1) % CLK_DIV : 0;
            m_prev_en = enable ? 1 : 0;
        end
        m_prev_a1 = int'(ad1_data);
        m_prev_a2 = int'(ad2_data);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Holds one pin pair for a full sample period so exactly one strobe sees it.
    task automatic feed(input logic [DW-1:0] a1, input logic [DW-1:0] a2);
        ad1_data = a1;
        ad2_data = a2;
        tick(CLK_DIV);
    endtask

    task automatic chk_log(input string name, input int idx, input int e1, input int e2);
        if (idx < dut_log.size()) begin
            chk({name, "_ch1"}, dut_log[idx].c1, e1);
            chk({name, "_ch2"}, dut_log[idx].c2, e2);
        end else begin
            chk({name, "_present"}, dut_log.size(), idx + 1);
        end
    endtask

    int       pulses;
    logic [3:0] pat;

    initial begin
        rst_n = 1'b1; enable = 1'b0; decim_log2 = 3'd0; ovf_clr = 1'b0; m_ready = 1'b1;
        ad1_data = 12'hFFF; ad2_data = 12'h000;
        cyc = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_valid", int'(m_valid), 0);
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_clk", int'(ad1_clk) + int'(ad2_clk), 0);
        chk("reset_ch1", int'(m_ch1), 0);
        chk("reset_ch2", int'(m_ch2), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Full-scale pass-through at k = 0.
        enable = 1'b1;
        pulses = 0; pat = 4'd0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (m_valid) begin
                pulses++;
                chk("s1_ch1", int'(m_ch1), 2047);
                chk("s1_ch2", int'(m_ch2), -2048);
            end
            if (i >= 3 && i <= 6) pat = {pat[2:0], ad1_clk};
        end
        chk("s1_pulses", pulses, 4);
        chk("s1_clk_pattern", int'(pat), 4'b1100);

        // k = 2 boxcar: (0+1+2+3)>>>2 = 1, (-1-2-3-4)>>>2 = -3.
        enable = 1'b0; tick(2);
        dut_log.delete();
        decim_log2 = 3'd2; enable = 1'b1;
        feed(12'h800, 12'h7FF); feed(12'h801, 12'h7FE);
        feed(12'h802, 12'h7FD); feed(12'h803, 12'h7FC);
        tick(3);
        chk("s2_count", dut_log.size(), 1);
        chk_log("s2", 0, 1, -3);

        // Back-pressure: four entries kept, fifth dropped.
        enable = 1'b0; tick(2);
        m_ready = 1'b0; decim_log2 = 3'd0; dut_log.delete();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) feed(12'(12'h810 + i), 12'(12'h7F0 - i));
        enable = 1'b0;
        tick(3);
        chk("s3_ovf_set", int'(overflow), 1);
        m_ready = 1'b1;
        tick(6);
        chk("s3_count", dut_log.size(), 4);
        for (int i = 0; i < 4; i++) chk_log("s3", i, 16 + i, -16 - i);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("s3_ovf_clr", int'(overflow), 0);

        // Push into a full FIFO while it is being popped: nothing lost.
        tick(2);
        m_ready = 1'b0; dut_log.delete();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) feed(12'(12'h820 + i), 12'(12'h7E0 - i));
        m_ready = 1'b1; enable = 1'b0;
        tick(1);
        m_ready = 1'b0;
        chk("s4_no_ovf", int'(overflow), 0);
        m_ready = 1'b1;
        tick(6);
        chk("s4_count", dut_log.size(), 5);
        for (int i = 0; i < 5; i++) chk_log("s4", i, 32 + i, -32 - i);

        // Exponent change 3 -> 0 mid-block: 8-sample average, then single samples.
        tick(2);
        dut_log.delete();
        decim_log2 = 3'd3; enable = 1'b1;
        for (int i = 0; i < 3; i++) feed(12'(12'h800 + i), 12'(12'h7FF - i));
        decim_log2 = 3'd0;
        for (int i = 3; i < 8; i++) feed(12'(12'h800 + i), 12'(12'h7FF - i));
        feed(12'h900, 12'h700);
        feed(12'hA00, 12'h600);
        enable = 1'b0;
        tick(3);
        chk("s5_count", dut_log.size(), 3);
        chk_log("s5_avg8", 0, 3, -5);
        chk_log("s5_single_a", 1, 256, -256);
        chk_log("s5_single_b", 2, 512, -512);

        // Disable mid-block: clocks stop, partial block discarded, FIFO drains.
        m_ready = 1'b0; dut_log.delete();
        enable = 1'b1;
        feed(12'h840, 12'h7C0); feed(12'h841, 12'h7BF);
        decim_log2 = 3'd2;
        feed(12'h850, 12'h7B0); feed(12'h851, 12'h7AF);
        enable = 1'b0;
        tick(2);
        chk("s6_clk_off", int'(ad1_clk) + int'(ad2_clk), 0);
        tick(10);
        chk("s6_held", dut_log.size(), 0);
        m_ready = 1'b1;
        tick(4);
        chk("s6_count", dut_log.size(), 2);
        chk_log("s6_a", 0, 64, -64);
        chk_log("s6_b", 1, 65, -65);

        // Reset with three entries queued and a partial block in flight.
        m_ready = 1'b0; dut_log.delete(); decim_log2 = 3'd0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) feed(12'(12'h860 + i), 12'(12'h7A0 - i));
        decim_log2 = 3'd2;
        feed(12'h870, 12'h790); feed(12'h871, 12'h78F);
        chk("s7_pre_valid", int'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("s7_rst_valid", int'(m_valid), 0);
        chk("s7_rst_ovf", int'(overflow), 0);
        chk("s7_rst_clk", int'(ad1_clk) + int'(ad2_clk), 0);
        chk("s7_rst_ch1", int'(m_ch1), 0);
        tick(2);
        rst_n = 1'b1; m_ready = 1'b1; decim_log2 = 3'd0;
        feed(12'hC00, 12'h400);
        tick(3);
        chk("s7_count", dut_log.size(), 1);
        chk_log("s7_post", 0, 1024, -1024);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
